// File: rtl/if_stage.sv
// Instruction fetch: PC register, next-PC select and IF/ID register; a fetched word reaches IFID_instr one edge after PC.
// A branch flush outranks a stall. A stall holds PC and IF/ID. A jump flush applies only when neither is active.
module if_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          IMEM_ADDR_W = 8,
    parameter int          CNT_W       = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [31:0]            imem_rdata,
    input  logic                   stall,
    input  logic                   EXMEM_PCSrc,
    input  logic [31:0]            EXMEM_branch_target,
    input  logic                   id_jump,
    input  logic [25:0]            id_jump_index,
    output logic [31:0]            PC,
    output logic [31:0]            instr,
    output logic [31:0]            IFID_instr,
    output logic [31:0]            IFID_PCplus4,
    output logic [CNT_W-1:0]       fetch_count,
    output logic [CNT_W-1:0]       stall_count,
    output logic [CNT_W-1:0]       flush_count
);

    typedef enum logic [1:0] {
        ACT_BRANCH = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_JUMP   = 2'd2,
        ACT_FETCH  = 2'd3
    } act_e;

    localparam logic [31:0]      PC_RST  = {RESET_PC[31:2], 2'b00};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      pc_q, pc_d;
    logic [31:0]      ifid_instr_q, ifid_instr_d;
    logic [31:0]      ifid_pc4_q, ifid_pc4_d;
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [31:0]      pc_plus4;
    act_e             act;

    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        act = ACT_FETCH;
        if (EXMEM_PCSrc) begin
            act = ACT_BRANCH;
        end else if (stall) begin
            act = ACT_HOLD;
        end else if (id_jump) begin
            act = ACT_JUMP;
        end
    end

    always_comb begin
        pc_d         = pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc4_d   = ifid_pc4_q;
        fetch_cnt_d  = fetch_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        unique case (act)
            ACT_BRANCH: begin
                pc_d         = {EXMEM_branch_target[31:2], 2'b00};
                ifid_instr_d = 32'h0;
                ifid_pc4_d   = 32'h0;
                flush_cnt_d  = flush_cnt_q + CNT_ONE;
            end
            ACT_HOLD: begin
                // IF/ID holds, so a pending jump in ID is seen again next cycle
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            ACT_JUMP: begin
                pc_d         = {ifid_pc4_q[31:28], id_jump_index, 2'b00};
                ifid_instr_d = 32'h0;
                ifid_pc4_d   = 32'h0;
                flush_cnt_d  = flush_cnt_q + CNT_ONE;
            end
            ACT_FETCH: begin
                pc_d         = pc_plus4;
                ifid_instr_d = imem_rdata;
                ifid_pc4_d   = pc_plus4;
                // all-zero word is a bubble, not a real fetch
                if (imem_rdata != 32'h0) begin
                    fetch_cnt_d = fetch_cnt_q + CNT_ONE;
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q         <= PC_RST;
            ifid_instr_q <= 32'h0;
            ifid_pc4_q   <= 32'h0;
            fetch_cnt_q  <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            fetch_cnt_q  <= fetch_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign imem_addr    = pc_q[IMEM_ADDR_W+1:2];
    assign PC           = pc_q;
    assign instr        = imem_rdata;
    assign IFID_instr   = ifid_instr_q;
    assign IFID_PCplus4 = ifid_pc4_q;
    assign fetch_count  = fetch_cnt_q;
    assign stall_count  = stall_cnt_q;
    assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: behavioural reference pushes expected state per edge into a queue, popped after the edge.
module tb_if_stage;

    logic        clock;
    logic        reset;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        EXMEM_PCSrc;
    logic [31:0] EXMEM_branch_target;
    logic        id_jump;
    logic [25:0] id_jump_index;
    logic [31:0] PC, instr, IFID_instr, IFID_PCplus4;
    logic [31:0] fetch_count, stall_count, flush_count;

    if_stage dut (
        .clock(clock), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .stall(stall), .EXMEM_PCSrc(EXMEM_PCSrc), .EXMEM_branch_target(EXMEM_branch_target),
        .id_jump(id_jump), .id_jump_index(id_jump_index), .PC(PC), .instr(instr),
        .IFID_instr(IFID_instr), .IFID_PCplus4(IFID_PCplus4), .fetch_count(fetch_count),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // word address 5 (PC 20) holds a NOP; every other word is nonzero
    function automatic logic [31:0] word_at(input logic [7:0] a);
        return (a == 8'd5) ? 32'h0 : {16'hC0DE, 8'h5A, a};
    endfunction

    assign imem_rdata = word_at(imem_addr);

    typedef struct {
        logic [31:0] pc, ir, p4, fc, sc, flc;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [31:0] m_pc, m_ir, m_p4, m_fc, m_sc, m_flc;
    int          n_cmp, n_bad;

    task automatic model_reset();
        m_pc = 0; m_ir = 0; m_p4 = 0; m_fc = 0; m_sc = 0; m_flc = 0;
    endtask

    // drive one cycle of inputs, push the expected post-edge state, then advance past the edge
    task automatic step(input logic pcsrc, input logic [31:0] tgt, input logic stl,
                        input logic jmp, input logic [25:0] idx);
        logic [31:0] rd;
        exp_t x;
        EXMEM_PCSrc = pcsrc; EXMEM_branch_target = tgt; stall = stl;
        id_jump = jmp; id_jump_index = idx;
        rd = word_at(m_pc[9:2]);
        if (pcsrc) begin
            m_pc = {tgt[31:2], 2'b00}; m_ir = 0; m_p4 = 0; m_flc = m_flc + 1;
        end else if (stl) begin
            m_sc = m_sc + 1;
        end else if (jmp) begin
            m_pc = {m_p4[31:28], idx, 2'b00}; m_ir = 0; m_p4 = 0; m_flc = m_flc + 1;
        end else begin
            m_ir = rd; m_p4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
            if (rd != 0) m_fc = m_fc + 1;
        end
        x.pc = m_pc; x.ir = m_ir; x.p4 = m_p4; x.fc = m_fc; x.sc = m_sc; x.flc = m_flc;
        sb.push_back(x);
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        EXMEM_PCSrc = 0; EXMEM_branch_target = 0; stall = 0; id_jump = 0; id_jump_index = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        idle_inputs();
        model_reset();
        #12;
        n_cmp++;
        if ({PC, IFID_instr, IFID_PCplus4, fetch_count, stall_count, flush_count} !== 192'h0) begin
            n_bad++;
            $display("FAIL reset_state: pc=%h ir=%h p4=%h fc=%0d sc=%0d flc=%0d, want all zero",
                     PC, IFID_instr, IFID_PCplus4, fetch_count, stall_count, flush_count);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_fetch();
        for (int i = 0; i < 9; i++) begin
            n_cmp++;
            if (imem_addr !== m_pc[9:2] || instr !== word_at(m_pc[9:2])) begin
                n_bad++;
                $display("FAIL fetch_addr %0d: addr=%h instr=%h, want addr=%h instr=%h",
                         i, imem_addr, instr, m_pc[9:2], word_at(m_pc[9:2]));
            end
            step(0, 0, 0, 0, 0);
            e = sb.pop_front();
            n_cmp++;
            if ({PC, IFID_instr, IFID_PCplus4, fetch_count, stall_count, flush_count} !==
                {e.pc, e.ir, e.p4, e.fc, e.sc, e.flc}) begin
                n_bad++;
                $display("FAIL fetch %0d: pc=%h ir=%h p4=%h fc=%0d, want pc=%h ir=%h p4=%h fc=%0d",
                         i, PC, IFID_instr, IFID_PCplus4, fetch_count, e.pc, e.ir, e.p4, e.fc);
            end
            if (i == 2) begin
                n_cmp++;
                if (PC !== 32'd12 || IFID_PCplus4 !== 32'd12 || fetch_count !== 32'd3) begin
                    n_bad++;
                    $display("FAIL fetch_three: pc=%0d p4=%0d fc=%0d, want 12 12 3",
                             PC, IFID_PCplus4, fetch_count);
                end
            end
        end
        // words at PCs 0..32 fetched; the one at 20 is a NOP
        n_cmp++;
        if (PC !== 32'd36 || fetch_count !== 32'd8) begin
            n_bad++;
            $display("FAIL nop_not_counted: pc=%0d fc=%0d, want 36 8", PC, fetch_count);
        end
    endtask

    task automatic test_jump();
        step(0, 0, 0, 1, 26'd11);
        e = sb.pop_front();
        n_cmp++;
        if (PC !== 32'd44 || IFID_instr !== 32'h0 || IFID_PCplus4 !== 32'h0 || flush_count !== 32'd1
            || PC !== e.pc || fetch_count !== e.fc) begin
            n_bad++;
            $display("FAIL jump: pc=%0d ir=%h p4=%h flc=%0d fc=%0d, want 44 0 0 1 %0d",
                     PC, IFID_instr, IFID_PCplus4, flush_count, fetch_count, e.fc);
        end
    endtask

    task automatic test_stall();
        step(0, 0, 1, 0, 0);
        e = sb.pop_front();
        n_cmp++;
        if (PC !== 32'd44 || IFID_instr !== e.ir || IFID_PCplus4 !== e.p4 || stall_count !== 32'd1
            || flush_count !== e.flc) begin
            n_bad++;
            $display("FAIL stall_hold: pc=%0d ir=%h p4=%h sc=%0d, want 44 %h %h 1",
                     PC, IFID_instr, IFID_PCplus4, stall_count, e.ir, e.p4);
        end
        step(0, 0, 0, 0, 0);
        e = sb.pop_front();
        n_cmp++;
        if (PC !== 32'd48 || IFID_PCplus4 !== 32'd48 || IFID_instr !== word_at(8'd11) || stall_count !== 32'd1) begin
            n_bad++;
            $display("FAIL stall_release: pc=%0d p4=%0d ir=%h sc=%0d, want 48 48 %h 1",
                     PC, IFID_PCplus4, IFID_instr, stall_count, word_at(8'd11));
        end
    endtask

    task automatic test_priority();
        logic [31:0] sc0, flc0;
        sc0 = stall_count; flc0 = flush_count;
        step(1, 32'd91, 1, 1, 26'h3FF_FFFF);
        e = sb.pop_front();
        n_cmp++;
        if (PC !== 32'd88 || IFID_instr !== 32'h0 || flush_count !== flc0 + 32'd1 || stall_count !== sc0) begin
            n_bad++;
            $display("FAIL branch_priority: pc=%0d ir=%h flc=%0d sc=%0d, want 88 0 %0d %0d",
                     PC, IFID_instr, flush_count, stall_count, flc0 + 32'd1, sc0);
        end
        // jump under stall waits, then fires from the held IF/ID; upper PC nibble comes from IF/ID PC+4
        step(1, 32'h7000_0100, 0, 0, 0);
        void'(sb.pop_front());
        step(0, 0, 0, 0, 0);
        void'(sb.pop_front());
        step(0, 0, 1, 1, 26'h12345);
        void'(sb.pop_front());
        step(0, 0, 0, 1, 26'h12345);
        e = sb.pop_front();
        n_cmp++;
        if (PC !== 32'h7004_8D14 || PC !== e.pc || flush_count !== e.flc || stall_count !== e.sc) begin
            n_bad++;
            $display("FAIL jump_after_stall: pc=%h flc=%0d sc=%0d, want %h %0d %0d",
                     PC, flush_count, stall_count, 32'h7004_8D14, e.flc, e.sc);
        end
    endtask

    task automatic test_async_reset();
        step(1, 32'd60, 0, 0, 0);
        e = sb.pop_front();
        n_cmp++;
        if (PC !== 32'd60) begin
            n_bad++;
            $display("FAIL pre_reset_pc: pc=%0d, want 60", PC);
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({PC, IFID_instr, IFID_PCplus4, fetch_count, stall_count, flush_count} !== 192'h0) begin
            n_bad++;
            $display("FAIL async_reset: pc=%h ir=%h p4=%h fc=%0d sc=%0d flc=%0d, want all zero",
                     PC, IFID_instr, IFID_PCplus4, fetch_count, stall_count, flush_count);
        end
        EXMEM_PCSrc = 1; EXMEM_branch_target = 32'd100;
        @(posedge clock);
        #1;
        n_cmp++;
        if (PC !== 32'h0 || flush_count !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_held: pc=%0d flc=%0d, want 0 0", PC, flush_count);
        end
        reset = 1'b1;
        model_reset();
        step(0, 0, 0, 0, 0);
        e = sb.pop_front();
        n_cmp++;
        if (PC !== 32'd4 || IFID_PCplus4 !== 32'd4 || IFID_instr !== word_at(8'd0) || fetch_count !== 32'd1) begin
            n_bad++;
            $display("FAIL resume_after_reset: pc=%0d p4=%0d ir=%h fc=%0d, want 4 4 %h 1",
                     PC, IFID_PCplus4, IFID_instr, fetch_count, word_at(8'd0));
        end
    endtask

    task automatic test_wrap();
        step(1, 32'hFFFF_FFFF, 0, 0, 0);
        void'(sb.pop_front());
        step(0, 0, 0, 0, 0);
        e = sb.pop_front();
        n_cmp++;
        if (PC !== 32'h0 || IFID_PCplus4 !== 32'h0 || IFID_instr !== word_at(8'hFF)) begin
            n_bad++;
            $display("FAIL pc_wrap: pc=%h p4=%h ir=%h, want 0 0 %h", PC, IFID_PCplus4, IFID_instr, word_at(8'hFF));
        end
    endtask

    task automatic test_back_to_back();
        logic pcsrc, stl, jmp;
        for (int i = 0; i < 300; i++) begin
            pcsrc = ($urandom_range(0, 7) == 0);
            stl   = ($urandom_range(0, 3) == 0);
            jmp   = ($urandom_range(0, 5) == 0);
            if (i < 2) begin
                pcsrc = 1'b1;
            end
            step(pcsrc, {$urandom_range(0, 15), 4'h0, 16'h0, 8'($urandom_range(0, 255))},
                 stl, jmp, 26'($urandom_range(0, 300)));
            e = sb.pop_front();
            n_cmp++;
            if ({PC, IFID_instr, IFID_PCplus4, fetch_count, stall_count, flush_count} !==
                {e.pc, e.ir, e.p4, e.fc, e.sc, e.flc} || PC[1:0] !== 2'b00) begin
                n_bad++;
                $display("FAIL b2b %0d: pc=%h ir=%h p4=%h fc=%0d sc=%0d flc=%0d, want pc=%h ir=%h p4=%h fc=%0d sc=%0d flc=%0d",
                         i, PC, IFID_instr, IFID_PCplus4, fetch_count, stall_count, flush_count,
                         e.pc, e.ir, e.p4, e.fc, e.sc, e.flc);
            end
        end
        idle_inputs();
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_fetch();
        test_jump();
        test_stall();
        test_priority();
        test_async_reset();
        test_wrap();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
